instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/cpu_pkg.sv | 18 +
 rtl/fetch_skid_buffer.sv | 91 +++++++++
 rtl/instruction_fetch.sv | 104 ++++++++++
 tb/tb_instruction_fetch.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encodings, reset address and the NOP word.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SQUASH = 2'd2,
    ST_FULL   = 2'd3
  } if_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// IF/ID pipeline register with a one-entry skid buffer that catches a word
// arriving while decode is stalled.
module fetch_skid_buffer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstb,
  input  logic        flush,
  input  logic        stall,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        skid_write,
  output logic        skid_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic        advance;

  // IF/ID may take a new entry when it is empty or decode is ready.
  assign advance = !valid_q || !stall;

  always_comb begin
    instr_d      = instr_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_valid_d = skid_valid_q;
    skid_write   = 1'b0;
    if (flush) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
    end else if (advance) begin
      if (skid_valid_q) begin
        instr_d      = skid_instr_q;
        pc_d         = skid_pc_q;
        valid_d      = 1'b1;
        skid_valid_d = in_valid;
        skid_write   = in_valid;
        if (in_valid) begin
          skid_instr_d = in_instr;
          skid_pc_d    = in_pc;
        end
      end else if (in_valid) begin
        instr_d = in_instr;
        pc_d    = in_pc;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else if (in_valid) begin
      skid_instr_d = in_instr;
      skid_pc_d    = in_pc;
      skid_valid_d = 1'b1;
      skid_write   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      instr_q      <= NOP_WORD;
      pc_q         <= 32'h0000_0000;
      valid_q      <= 1'b0;
      skid_instr_q <= NOP_WORD;
      skid_pc_q    <= 32'h0000_0000;
      skid_valid_q <= 1'b0;
    end else begin
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign instr_out   = instr_q;
  assign pc_out      = pc_q;
  assign instr_valid = valid_q;
  assign skid_valid  = skid_valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: single-outstanding-request memory FSM and fetch PC,
// feeding the IF/ID register through fetch_skid_buffer.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rstb,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        instr_valid
);

  if_state_e   state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        buf_in_valid;
  logic        skid_write;
  logic        skid_valid;
  logic        outstanding;

  assign outstanding  = (state_q == ST_WAIT) || (state_q == ST_SQUASH);
  assign buf_in_valid = (state_q == ST_WAIT) && imem_valid && !redirect_valid;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    if (redirect_valid) begin
      fetch_pc_d = align_word(redirect_pc);
      // A request still in flight must be drained before a new one is issued.
      state_d = (outstanding && !imem_valid) ? ST_SQUASH : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d    = ST_WAIT;
          req_addr_d = fetch_pc_q;
        end
        ST_WAIT: begin
          if (imem_valid) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            if (skid_write) begin
              state_d = ST_FULL;
            end else begin
              req_addr_d = fetch_pc_q + 32'd4;
            end
          end
        end
        ST_SQUASH: begin
          if (imem_valid) state_d = ST_IDLE;
        end
        ST_FULL: begin
          if (!stall) begin
            state_d    = ST_WAIT;
            req_addr_d = fetch_pc_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  assign imem_req  = outstanding;
  assign imem_addr = req_addr_q;

  fetch_skid_buffer u_skid (
    .clk         (clk),
    .rstb        (rstb),
    .flush       (redirect_valid),
    .stall       (stall),
    .in_valid    (buf_in_valid),
    .in_instr    (imem_rdata),
    .in_pc       (req_addr_q),
    .skid_write  (skid_write),
    .skid_valid  (skid_valid),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .instr_valid (instr_valid)
  );

  assign pc_plus4 = pc_out + 32'd4;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural instruction memory
// of configurable latency.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rstb;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        instr_valid;

  int n_cmp = 0;
  int n_err = 0;
  int mem_cnt = 0;
  int mem_lat = 1;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rstb           (rstb),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_valid     (imem_valid),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .pc_plus4       (pc_plus4),
    .instr_valid    (instr_valid)
  );

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                         input logic e_iv, input logic [31:0] e_pc);
    chk({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, e_req});
    chk({tag, ".imem_addr"}, imem_addr, e_addr);
    chk({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, e_iv});
    if (e_iv) begin
      chk({tag, ".pc_out"}, pc_out, e_pc);
      chk({tag, ".pc_plus4"}, pc_plus4, e_pc + 32'd4);
      chk({tag, ".instr_out"}, instr_out, mem_word(e_pc));
    end
    $display("%s: req=%0b addr=%08h iv=%0b pc=%08h instr=%08h", tag, imem_req, imem_addr,
             instr_valid, pc_out, instr_out);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".imem_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, ".imem_addr"}, imem_addr, 32'h0000_0000);
    chk({tag, ".instr_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, ".instr_out"}, instr_out, 32'h0000_0000);
    chk({tag, ".pc_out"}, pc_out, 32'h0000_0000);
    chk({tag, ".pc_plus4"}, pc_plus4, 32'h0000_0004);
    $display("%s: reset values observed", tag);
  endtask

  // Memory answers in the mem_lat-th cycle a request has been presented.
  task automatic mem_tick();
    if (imem_req) begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        imem_valid = 1'b1;
        imem_rdata = mem_word(imem_addr);
        mem_cnt    = 0;
      end else begin
        imem_valid = 1'b0;
        imem_rdata = 32'hBAD0_BAD0;
      end
    end else begin
      imem_valid = 1'b0;
      imem_rdata = 32'hBAD0_BAD0;
      mem_cnt    = 0;
    end
  endtask

  task automatic step(input logic s, input logic rv, input logic [31:0] rpc);
    mem_tick();
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    rstb = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_valid = 1'b0; imem_rdata = 32'h0;

    //            stall rv   rpc            req   addr          iv    pc
    vecs[0]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h0000_0000, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,       1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,       1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C};
    vecs[8]  = '{1'b0, 1'b1, 32'h103,     1'b1, 32'h0000_0014, 1'b1, 32'h0000_0010};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0000_0014, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h0000_0100, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100};
    vecs[12] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h0000_0108, 1'b1, 32'h0000_0104};

    repeat (2) @(negedge clk);
    chk_reset("rst_init");
    rstb = 1'b1;
    @(negedge clk);

    // 1-cycle memory: streaming, 3-cycle stall into the skid, redirect.
    for (int i = 0; i < 13; i++) begin
      chk_out($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_iv, vecs[i].e_pc);
      step(vecs[i].stall, vecs[i].rv, vecs[i].rpc);
    end

    // Reset in the middle of an outstanding request, response during reset.
    rstb = 1'b0; imem_valid = 1'b1; imem_rdata = mem_word(32'h10C);
    stall = 1'b0; redirect_valid = 1'b0;
    #1;
    chk_reset("rst_async");
    @(negedge clk);
    chk_reset("rst_hold");
    rstb = 1'b1; imem_valid = 1'b0; mem_cnt = 0; mem_lat = 3;
    @(negedge clk);

    // 3-cycle memory: address held, one word per three cycles, bubbles between.
    for (int c = 1; c <= 10; c++) begin
      logic        e_iv;
      logic [31:0] e_pc;
      logic [31:0] e_addr;
      e_iv   = (c >= 4) && ((c % 3) == 1);
      e_pc   = e_iv ? 32'(4 * ((c - 4) / 3)) : 32'h0;
      e_addr = 32'(4 * ((c - 1) / 3));
      chk_out($sformatf("lat3_c%0d", c), 1'b1, e_addr, e_iv, e_pc);
      step(1'b0, c == 10, 32'h0000_0103);
    end

    // Redirect while waiting, then again while squashing.
    chk_out("sq_c11", 1'b1, 32'h0000_000C, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0203);
    chk_out("sq_c12", 1'b1, 32'h0000_000C, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk_out("sq_c13", 1'b0, 32'h0000_000C, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    for (int c = 14; c <= 16; c++) begin
      chk_out($sformatf("sq_c%0d", c), 1'b1, 32'h0000_0200, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
    end
    chk_out("sq_c17", 1'b1, 32'h0000_0204, 1'b1, 32'h0000_0200);
    step(1'b0, 1'b1, 32'hFFFF_FFFF);

    // Wrap of the fetch PC at the top of the address space.
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid && pc_out == 32'hFFFF_FFFC) begin
        found = 1'b1;
        break;
      end
      step(1'b0, 1'b0, 32'h0);
    end
    chk("wrap.reached", {31'd0, found}, 32'd1);
    chk("wrap.instr_out", instr_out, mem_word(32'hFFFF_FFFC));
    chk("wrap.pc_plus4", pc_plus4, 32'h0000_0000);
    chk("wrap.imem_addr", imem_addr, 32'h0000_0000);
    $display("wrap: pc=%08h pc_plus4=%08h next_addr=%08h", pc_out, pc_plus4, imem_addr);
    repeat (3) step(1'b0, 1'b0, 32'h0);
    chk_out("wrap_next", 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
